// File: rtl/key_pkg.sv
// Shared types and constants for the pushbutton debouncer.
// Optional auto-repeat is enabled with the KEY_REPEAT_EN macro.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REL_WAIT
    } key_state_t;

    localparam int unsigned CNT_W = 5;
`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_W = 10;
`endif

    // Prescaler divide ratio; clamped so a sub-kHz clock still ticks every cycle.
    function automatic int unsigned ms_div(input int unsigned clk_freq);
        return (clk_freq / 1000 == 0) ? 1 : clk_freq / 1000;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, ms-tick debounce FSM and registered press pulse.
// With KEY_REPEAT_EN defined, a held key also emits auto-repeat pulses.
module key_debounce_cell
    import key_pkg::*;
#(
`ifdef KEY_REPEAT_EN
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100,
`endif
    parameter int unsigned DEBOUNCE_MS     = 20
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic ms_tick,
    input  logic key_raw,
    output logic key_pulse,
    output logic key_level
);

    logic             sync_meta_q, sync_n_q;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             cnt_done;
`ifdef KEY_REPEAT_EN
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_first_q, rpt_first_d;
`endif

    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign cnt_done = ms_tick && (32'(cnt_q) + 32'd1 >= DEBOUNCE_MS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!sync_n_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync_n_q) begin
                    state_d = IDLE;
                end else if (cnt_done) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else if (ms_tick) begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (sync_n_q) begin
                    state_d = REL_WAIT;
                    cnt_d   = '0;
                end
            end
            REL_WAIT: begin
                if (!sync_n_q) begin
                    state_d = PRESSED;
                end else if (cnt_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ms_tick) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef KEY_REPEAT_EN
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
        // Counts only while steadily held; a release bounce pauses it.
        if (state_q == PRESSED && state_d == PRESSED && ms_tick) begin
            if (32'(rpt_q) + 32'd1 >= (rpt_first_q ? REPEAT_RATE_MS : REPEAT_DELAY_MS)) begin
                pulse_d     = 1'b1;
                rpt_d       = '0;
                rpt_first_d = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
        if (state_d == IDLE) begin
            rpt_d       = '0;
            rpt_first_d = 1'b0;
        end
`endif

        level_d = (state_d == PRESSED) || (state_d == REL_WAIT);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_meta_q <= 1'b1;
            sync_n_q    <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
            level_q     <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
`endif
        end else begin
            sync_meta_q <= key_raw;
            sync_n_q    <= sync_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            level_q     <= level_d;
`ifdef KEY_REPEAT_EN
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    assign key_pulse = pulse_q;
    assign key_level = level_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS active-low pushbuttons into single-cycle press pulses.
// Define KEY_REPEAT_EN to add auto-repeat pulses while a key is held.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 12,
    parameter int unsigned CLK_FREQ        = 50_000_000,
`ifdef KEY_REPEAT_EN
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100,
`endif
    parameter int unsigned DEBOUNCE_MS     = 20
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic [NUM_KEYS-1:0] key_level
);

    localparam int unsigned MS_DIV = ms_div(CLK_FREQ);
    localparam int unsigned PRE_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             ms_tick;

    assign ms_tick = (pre_q == PRE_W'(MS_DIV - 1));

    always_comb begin
        pre_d = ms_tick ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_cell #(
`ifdef KEY_REPEAT_EN
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS),
`endif
            .DEBOUNCE_MS     (DEBOUNCE_MS)
        ) u_cell (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .ms_tick   (ms_tick),
            .key_raw   (key_raw[k]),
            .key_pulse (key_pulse[k]),
            .key_level (key_level[k])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random bouncing, checked against
// a window model (a key toggles once its raw input has been steadily opposite long enough).
module tb_key_debounce;

    localparam int unsigned NUM_KEYS = 12;
    localparam int unsigned DEB      = 4;
    localparam int unsigned SYNC_LAT = 2;
    localparam logic [NUM_KEYS-1:0] REL = '1;

    logic                sys_clk = 1'b0;
    logic                sys_rst = 1'b1;
    logic [NUM_KEYS-1:0] key_raw = '1;
    logic [NUM_KEYS-1:0] key_pulse;
    logic [NUM_KEYS-1:0] key_level;

    key_debounce #(
        .NUM_KEYS    (NUM_KEYS),
        .CLK_FREQ    (1000),
        .DEBOUNCE_MS (DEB)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .key_raw   (key_raw),
        .key_pulse (key_pulse),
        .key_level (key_level)
    );

    always #5 sys_clk = ~sys_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int t        = 0;

    // Raw samples taken at the most recent clock edges, newest first.
    logic [NUM_KEYS-1:0] hist [0:SYNC_LAT+DEB];
    logic [NUM_KEYS-1:0] m_level = '0;
    logic [NUM_KEYS-1:0] m_pulse = '0;

    int                  pulse_cnt [NUM_KEYS];
    int                  first_pulse_t [NUM_KEYS];
    logic [NUM_KEYS-1:0] ever_level;
    logic                saw_801;

    task automatic check(input string tag, input logic [NUM_KEYS-1:0] obs,
                         input logic [NUM_KEYS-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d: observed %h expected %h", tag, t, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NUM_KEYS; i++) begin
            pulse_cnt[i]     = 0;
            first_pulse_t[i] = -1;
        end
        ever_level = '0;
        saw_801    = 1'b0;
        t          = 0;
    endtask

    task automatic model_edge();
        bit stable;
        if (sys_rst) begin
            for (int j = 0; j <= SYNC_LAT + DEB; j++) hist[j] = '1;
            m_level = '0;
            m_pulse = '0;
        end else begin
            for (int j = SYNC_LAT + DEB; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = key_raw;
            m_pulse = '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                stable = 1'b1;
                for (int j = SYNC_LAT; j <= SYNC_LAT + DEB; j++) begin
                    if ((!hist[j][i]) == m_level[i]) stable = 1'b0;
                end
                if (stable) begin
                    m_level[i] = !m_level[i];
                    m_pulse[i] = m_level[i];
                end
            end
        end
    endtask

    task automatic step(input logic [NUM_KEYS-1:0] raw, input logic rst);
        @(negedge sys_clk);
        key_raw = raw;
        sys_rst = rst;
        @(posedge sys_clk);
        model_edge();
        #1;
        check("key_pulse", key_pulse, m_pulse);
        check("key_level", key_level, m_level);
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_pulse[i]) begin
                if (pulse_cnt[i] == 0) first_pulse_t[i] = t;
                pulse_cnt[i]++;
            end
        end
        ever_level = ever_level | key_level;
        if (key_pulse == 12'h801) saw_801 = 1'b1;
        t++;
    endtask

    task automatic hold(input logic [NUM_KEYS-1:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b0);
    endtask

    initial begin
        logic [NUM_KEYS-1:0] rnd_raw;
        logic [NUM_KEYS-1:0] p3, p5, p2, p7, p801;
        p3   = ~(NUM_KEYS'(1) << 3);
        p5   = ~(NUM_KEYS'(1) << 5);
        p2   = ~(NUM_KEYS'(1) << 2);
        p7   = ~(NUM_KEYS'(1) << 7);
        p801 = ~NUM_KEYS'(12'h801);
        clear_stats();

        // Reset held with all keys released, then released.
        for (int k = 0; k < 3; k++) step(REL, 1'b1);
        check("reset_pulse", key_pulse, '0);
        check("reset_level", key_level, '0);
        hold(REL, 6);

        // Single clean press on key 3: 4-tick debounce plus 3 cycles of pipeline.
        clear_stats();
        hold(p3, 12);
        check_int("k3_latency", first_pulse_t[3], 6);
        hold(REL, 10);
        check_int("k3_pulses", pulse_cnt[3], 1);
        check_int("k3_level_seen", int'(ever_level[3]), 1);
        check("k3_released", key_level, '0);

        // Short glitches on key 5 never reach the debounce window.
        clear_stats();
        hold(p5, 2);
        hold(REL, 1);
        hold(p5, 2);
        hold(REL, 10);
        check_int("k5_pulses", pulse_cnt[5], 0);
        check_int("k5_level_seen", int'(ever_level[5]), 0);

        // Keys 0 and 11 fall together.
        clear_stats();
        hold(p801, 10);
        check_int("k0_k11_same_cycle", int'(saw_801), 1);
        hold(REL, 10);

        // Key 2 bounces high while held: no second pulse, level holds.
        clear_stats();
        hold(p2, 8);
        hold(REL, 2);
        hold(p2, 10);
        check("k2_level_held", key_level, NUM_KEYS'(1) << 2);
        hold(REL, 10);
        check_int("k2_pulses", pulse_cnt[2], 1);

        // Reset lands mid-debounce of key 7 which stays held through it.
        clear_stats();
        hold(p7, 3);
        step(p7, 1'b1);
        step(p7, 1'b1);
        check_int("k7_no_pulse_pre_reset", pulse_cnt[7], 0);
        clear_stats();
        hold(p7, 12);
        check_int("k7_latency_after_reset", first_pulse_t[7], 6);
        check_int("k7_pulses", pulse_cnt[7], 1);
        hold(REL, 10);

        // Random bouncing: fast chatter then slower presses, with a reset in between.
        rnd_raw = REL;
        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if ($urandom_range(3) == 0) rnd_raw[i] = ~rnd_raw[i];
            end
            step(rnd_raw, 1'b0);
        end
        step(rnd_raw, 1'b1);
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if ($urandom_range(11) == 0) rnd_raw[i] = ~rnd_raw[i];
            end
            step(rnd_raw, 1'b0);
        end
        hold(REL, 10);
        check("final_level", key_level, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
